wavegen_dac_spi: RTL and testbench

//  Downstream of the wavegen AXI block: takes OUT_A/OUT_B (signed 16-bit) on each sample strobe and

---
 rtl/wavegen_dac_pkg.sv | 32 +++
 rtl/wavegen_dac_shifter.sv | 73 +++++++
 rtl/wavegen_dac_spi.sv | 114 +++++++++++
 tb/tb_wavegen_dac_spi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavegen_dac_pkg.sv
// rtl/wavegen_dac_pkg.sv - shared types, frame layout and frame builder for the wavegen DAC SPI link
package wavegen_dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP,
    FRAME_B,
    LDAC
  } state_e;

  localparam int unsigned CH     = 15;
  localparam int unsigned BUF    = 14;
  localparam int unsigned GA_N   = 13;
  localparam int unsigned SHDN_N = 12;

  // Signed sample becomes offset binary by flipping the sign bit; the DAC takes the top 12 bits.
  function automatic logic [15:0] build_frame(input logic ch, input logic en,
                                              input logic [15:0] sample, input logic gain);
    logic [15:0] f;
    logic [11:0] code;
    code      = {~sample[15], sample[14:4]};
    f         = '0;
    f[CH]     = ch;
    f[BUF]    = 1'b0;
    f[GA_N]   = gain;
    f[SHDN_N] = en;
    f[11:0]   = en ? code : 12'h000;
    return f;
  endfunction

endpackage

// File: rtl/wavegen_dac_shifter.sv
// rtl/wavegen_dac_shifter.sv - serialises one 16-bit frame as SPI mode 0 with a CLK_DIV half-period
module wavegen_dac_shifter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] frame_i,
  output logic        cs_n_o,
  output logic        sclk_o,
  output logic        sdi_o,
  output logic        done_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic             sdi_q;
  logic [3:0]       bit_q;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      sreg_q;
  logic             div_end;

  assign div_end = (div_q == DIV_LAST);
  // Combinational so the sequencer can raise CS_N and advance state on the very same edge.
  assign done_o  = active_q & sclk_q & div_end & (bit_q == 4'd0);
  assign cs_n_o  = cs_n_q;
  assign sclk_o  = sclk_q;
  assign sdi_o   = sdi_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      bit_q    <= 4'd0;
      div_q    <= '0;
      sreg_q   <= '0;
    end else if (!active_q) begin
      if (start_i) begin
        active_q <= 1'b1;
        cs_n_q   <= 1'b0;
        sclk_q   <= 1'b0;
        sdi_q    <= frame_i[15];
        bit_q    <= 4'd15;
        div_q    <= '0;
        sreg_q   <= frame_i;
      end
    end else if (div_end) begin
      div_q <= '0;
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else begin
        sclk_q <= 1'b0;
        if (bit_q == 4'd0) begin
          active_q <= 1'b0;
          cs_n_q   <= 1'b1;
          sdi_q    <= 1'b0;
        end else begin
          bit_q <= bit_q - 4'd1;
          sdi_q <= sreg_q[bit_q - 4'd1];
        end
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/wavegen_dac_spi.sv
// rtl/wavegen_dac_spi.sv - sequences frame A, gap, frame B and the LDAC pulse for each sample strobe
module wavegen_dac_spi
  import wavegen_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned LDAC_W  = 2,
  parameter logic        GAIN_1X = 1'b1
) (
  input  logic        lut_clk_i,
  input  logic        reset_i,
  input  logic        sample_stb_i,
  input  logic [15:0] in_a_i,
  input  logic [15:0] in_b_i,
  input  logic        enable_a_i,
  input  logic        enable_b_i,
  output logic        dac_cs_n_o,
  output logic        dac_sclk_o,
  output logic        dac_sdi_o,
  output logic        dac_ldac_n_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int unsigned CNT_MAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_W - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      frame_b_q;
  logic             ldac_n_q;
  logic             busy_q;
  logic             overrun_q;

  logic [15:0]      frame_a_d;
  logic [15:0]      shift_frame;
  logic             shift_start;
  logic             shift_done;

  assign frame_a_d   = build_frame(1'b0, enable_a_i, in_a_i, GAIN_1X);
  // Frame A goes straight from the inputs so CS_N can drop the cycle after the strobe.
  assign shift_frame = (state_q == IDLE) ? frame_a_d : frame_b_q;
  assign shift_start = ((state_q == IDLE) && sample_stb_i) ||
                       ((state_q == GAP) && (cnt_q == GAP_LAST));

  wavegen_dac_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk_i  (lut_clk_i),
    .reset_i(reset_i),
    .start_i(shift_start),
    .frame_i(shift_frame),
    .cs_n_o (dac_cs_n_o),
    .sclk_o (dac_sclk_o),
    .sdi_o  (dac_sdi_o),
    .done_o (shift_done)
  );

  always_ff @(posedge lut_clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_b_q <= '0;
      ldac_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= sample_stb_i && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (sample_stb_i) begin
            frame_b_q <= build_frame(1'b1, enable_b_i, in_b_i, GAIN_1X);
            busy_q    <= 1'b1;
            state_q   <= FRAME_A;
          end
        end
        FRAME_A: begin
          if (shift_done) begin
            cnt_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) state_q <= FRAME_B;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        FRAME_B: begin
          if (shift_done) begin
            cnt_q    <= '0;
            ldac_n_q <= 1'b0;
            state_q  <= LDAC;
          end
        end
        LDAC: begin
          if (cnt_q == LDAC_LAST) begin
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dac_ldac_n_o = ldac_n_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_wavegen_dac_spi.sv
// tb/tb_wavegen_dac_spi.sv - randomized self-checking bench for wavegen_dac_spi (default and fast timing)
module tb_wavegen_dac_spi;

  logic        clk;
  logic        rst[2];
  logic        stb[2];
  logic [15:0] ina[2];
  logic [15:0] inb[2];
  logic        ena[2];
  logic        enb[2];
  logic        cs_n[2];
  logic        sclk[2];
  logic        sdi[2];
  logic        ldac_n[2];
  logic        busy[2];
  logic        ovr[2];

  int errors = 0;
  int checks = 0;

  wavegen_dac_spi u_dut0 (
    .lut_clk_i(clk), .reset_i(rst[0]), .sample_stb_i(stb[0]), .in_a_i(ina[0]), .in_b_i(inb[0]),
    .enable_a_i(ena[0]), .enable_b_i(enb[0]), .dac_cs_n_o(cs_n[0]), .dac_sclk_o(sclk[0]),
    .dac_sdi_o(sdi[0]), .dac_ldac_n_o(ldac_n[0]), .busy_o(busy[0]), .overrun_o(ovr[0]));

  wavegen_dac_spi #(.CLK_DIV(1), .CS_GAP(1), .LDAC_W(1)) u_dut1 (
    .lut_clk_i(clk), .reset_i(rst[1]), .sample_stb_i(stb[1]), .in_a_i(ina[1]), .in_b_i(inb[1]),
    .enable_a_i(ena[1]), .enable_b_i(enb[1]), .dac_cs_n_o(cs_n[1]), .dac_sclk_o(sclk[1]),
    .dac_sdi_o(sdi[1]), .dac_ldac_n_o(ldac_n[1]), .busy_o(busy[1]), .overrun_o(ovr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive SPI/LDAC/BUSY observer, one lane per DUT, sampled on the falling edge.
  logic        p_sclk[2], p_cs[2], p_sdi[2], p_ldac[2], p_busy[2], p_ovr[2];
  logic [15:0] sh[2];
  logic [15:0] frm[2][256];
  int nbits[2]     = '{0, 0};
  int nfrm[2]      = '{0, 0};
  int nabort[2]    = '{0, 0};
  int cs_run[2]    = '{0, 0};
  int cs_len[2]    = '{0, 0};
  int ldac_run[2]  = '{0, 0};
  int ldac_len[2]  = '{0, 0};
  int nldac[2]     = '{0, 0};
  int misalign[2]  = '{0, 0};
  int busy_run[2]  = '{0, 0};
  int busy_len[2]  = '{0, 0};
  int ovr_run[2]   = '{0, 0};
  int ovr_len[2]   = '{0, 0};
  int novr[2]      = '{0, 0};
  int rise_gap[2]  = '{0, 0};
  int per_min[2]   = '{0, 0};
  int per_max[2]   = '{0, 0};
  int viol[2]      = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs_n[k] === 1'b0) cs_run[k]++;
      if (cs_n[k] === 1'b0 && p_cs[k] === 1'b1) begin
        nbits[k] = 0; rise_gap[k] = 0; per_min[k] = 1000; per_max[k] = 0;
      end
      rise_gap[k]++;
      if (sclk[k] === 1'b1 && p_sclk[k] === 1'b0 && cs_n[k] === 1'b0) begin
        sh[k] = {sh[k][14:0], sdi[k]};
        if (sdi[k] !== p_sdi[k]) viol[k]++;
        if (nbits[k] > 0) begin
          if (rise_gap[k] < per_min[k]) per_min[k] = rise_gap[k];
          if (rise_gap[k] > per_max[k]) per_max[k] = rise_gap[k];
        end
        rise_gap[k] = 0;
        nbits[k]++;
      end
      if (sclk[k] === 1'b1 && p_sclk[k] === 1'b1 && sdi[k] !== p_sdi[k]) viol[k]++;
      if (sclk[k] === 1'b1 && cs_n[k] === 1'b1) viol[k]++;
      if (cs_n[k] === 1'b1 && p_cs[k] === 1'b0) begin
        if (nbits[k] == 16) begin frm[k][nfrm[k] % 256] = sh[k]; nfrm[k]++; end
        else nabort[k]++;
        cs_len[k] = cs_run[k]; cs_run[k] = 0;
      end
      if (ldac_n[k] === 1'b0) ldac_run[k]++;
      if (ldac_n[k] === 1'b0 && p_ldac[k] === 1'b1 && !(cs_n[k] === 1'b1 && p_cs[k] === 1'b0))
        misalign[k]++;
      if (ldac_n[k] === 1'b1 && p_ldac[k] === 1'b0) begin
        ldac_len[k] = ldac_run[k]; ldac_run[k] = 0; nldac[k]++;
      end
      if (busy[k] === 1'b1) busy_run[k]++;
      if (busy[k] === 1'b0 && p_busy[k] === 1'b1) begin busy_len[k] = busy_run[k]; busy_run[k] = 0; end
      if (ovr[k] === 1'b1) ovr_run[k]++;
      if (ovr[k] === 1'b0 && p_ovr[k] === 1'b1) begin ovr_len[k] = ovr_run[k]; ovr_run[k] = 0; novr[k]++; end
      p_sclk[k] = sclk[k]; p_cs[k] = cs_n[k]; p_sdi[k] = sdi[k];
      p_ldac[k] = ldac_n[k]; p_busy[k] = busy[k]; p_ovr[k] = ovr[k];
    end
  end

  // Reference: offset-binary code by arithmetic, fields placed by weight.
  function automatic int exp_frame(input int ch, input int en, input logic [15:0] sample);
    int code;
    code = ((int'(sample) + 32768) % 65536) / 16;
    return ch * 32768 + 1 * 8192 + en * 4096 + (en != 0 ? code : 0);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [15:0] a, input logic [15:0] b,
                      input logic ea, input logic eb);
    ina[k] = a; inb[k] = b; ena[k] = ea; enb[k] = eb; stb[k] = 1'b1;
    tick();
    stb[k] = 1'b0;
    ina[k] = 16'($urandom); inb[k] = 16'($urandom); ena[k] = 1'($urandom); enb[k] = 1'($urandom);
  endtask

  task automatic wait_idle(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (busy[k] === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) rst[k] = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if ({cs_n[k], sclk[k], sdi[k], ldac_n[k], busy[k], ovr[k]} !== 6'b100100) begin
        errors++; $display("FAIL reset_outputs dut%0d: got %b want 100100", k,
                           {cs_n[k], sclk[k], sdi[k], ldac_n[k], busy[k], ovr[k]});
      end
      rst[k] = 1'b0;
    end
    repeat (10) tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (cs_n[k] !== 1'b1 || busy[k] !== 1'b0 || nfrm[k] != 0) begin
        errors++; $display("FAIL reset_idle dut%0d: cs_n=%b busy=%b frames=%0d want 1 0 0",
                           k, cs_n[k], busy[k], nfrm[k]);
      end
    end
  endtask

  task automatic run_and_check(input string name, input int k, input logic [15:0] a,
                               input logic [15:0] b, input logic ea, input logic eb);
    int base, lbase, vbase, fa, fb, d;
    bit ok;
    d = (k == 0) ? 2 : 1;
    base = nfrm[k]; lbase = nldac[k]; vbase = viol[k];
    fa = exp_frame(0, int'(ea), a); fb = exp_frame(1, int'(eb), b);
    send(k, a, b, ea, eb);
    checks++; if (cs_n[k] !== 1'b0 || busy[k] !== 1'b1 || sclk[k] !== 1'b0 || sdi[k] !== fa[15]) begin
      errors++; $display("FAIL %s_start: cs_n=%b busy=%b sclk=%b sdi=%b want 0 1 0 %b",
                         name, cs_n[k], busy[k], sclk[k], sdi[k], fa[15]);
    end
    wait_idle(k, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: busy never fell", name); end
    checks++; if (nfrm[k] != base + 2 || frm[k][base % 256] !== 16'(fa) || frm[k][(base + 1) % 256] !== 16'(fb)) begin
      errors++; $display("FAIL %s_frames: got n=%0d %h %h want n=%0d %h %h", name, nfrm[k] - base,
                         frm[k][base % 256], frm[k][(base + 1) % 256], 2, 16'(fa), 16'(fb));
    end
    checks++; if (nldac[k] - lbase != 1 || ldac_len[k] != d || misalign[k] != 0) begin
      errors++; $display("FAIL %s_ldac: pulses=%0d len=%0d misalign=%0d want 1 %0d 0",
                         name, nldac[k] - lbase, ldac_len[k], misalign[k], d);
    end
    checks++; if (busy_len[k] != 64 * d + 2 * d || cs_len[k] != 32 * d || viol[k] != vbase) begin
      errors++; $display("FAIL %s_timing: busy=%0d cs_low=%0d sdi_viol=%0d want %0d %0d 0",
                         name, busy_len[k], cs_len[k], viol[k] - vbase, 66 * d, 32 * d);
    end
  endtask

  task automatic test_basic();
    run_and_check("basic", 0, 16'h0000, 16'h7FFF, 1'b1, 1'b1);
    checks++; if (frm[0][(nfrm[0] - 2) % 256] !== 16'h3800 || frm[0][(nfrm[0] - 1) % 256] !== 16'hBFFF) begin
      errors++; $display("FAIL basic_const: got %h %h want 3800 bfff",
                         frm[0][(nfrm[0] - 2) % 256], frm[0][(nfrm[0] - 1) % 256]);
    end
  endtask

  task automatic test_disable();
    run_and_check("disable", 0, 16'h8000, 16'h1234, 1'b1, 1'b0);
    checks++; if (frm[0][(nfrm[0] - 2) % 256] !== 16'h3000 || frm[0][(nfrm[0] - 1) % 256] !== 16'hA000) begin
      errors++; $display("FAIL disable_const: got %h %h want 3000 a000",
                         frm[0][(nfrm[0] - 2) % 256], frm[0][(nfrm[0] - 1) % 256]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_and_check("random", 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, a2, b2;
    int base, obase;
    bit ok;
    a = 16'($urandom); b = 16'($urandom); a2 = ~a; b2 = ~b;
    base = nfrm[0]; obase = novr[0];
    send(0, a, b, 1'b1, 1'b1);
    repeat (9) tick();
    ina[0] = a2; inb[0] = b2; stb[0] = 1'b1;
    tick();
    stb[0] = 1'b0;
    checks++; if (ovr[0] !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b want 1", ovr[0]); end
    tick();
    checks++; if (ovr[0] !== 1'b0) begin errors++; $display("FAIL overrun_width: got %b want 0", ovr[0]); end
    wait_idle(0, ok);
    checks++; if (!ok || nfrm[0] != base + 2 || frm[0][base % 256] !== 16'(exp_frame(0, 1, a))
                  || frm[0][(base + 1) % 256] !== 16'(exp_frame(1, 1, b))) begin
      errors++; $display("FAIL overrun_frames: got %h %h want %h %h", frm[0][base % 256],
                         frm[0][(base + 1) % 256], 16'(exp_frame(0, 1, a)), 16'(exp_frame(1, 1, b)));
    end
    checks++; if (novr[0] - obase != 1 || ovr_len[0] != 1) begin
      errors++; $display("FAIL overrun_count: got %0d len %0d want 1 1", novr[0] - obase, ovr_len[0]);
    end
    run_and_check("back_to_back", 0, a2, b2, 1'b1, 1'b1);
    checks++; if (ovr[0] !== 1'b0 || novr[0] - obase != 1) begin
      errors++; $display("FAIL back_to_back_overrun: got %b count %0d want 0 1", ovr[0], novr[0] - obase);
    end
  endtask

  task automatic test_reset_mid();
    int base, lbase, abase;
    bit found;
    base = nfrm[0]; lbase = nldac[0]; abase = nabort[0]; found = 1'b0;
    send(0, 16'($urandom), 16'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (nfrm[0] == base + 1 && nbits[0] == 9) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_reach: frame B bit 7 not seen"); end
    rst[0] = 1'b1;
    tick();
    checks++; if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || ldac_n[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: cs_n=%b sclk=%b ldac_n=%b busy=%b want 1 0 1 0",
                         cs_n[0], sclk[0], ldac_n[0], busy[0]);
    end
    rst[0] = 1'b0;
    repeat (20) tick();
    checks++; if (nldac[0] != lbase || nabort[0] - abase != 1) begin
      errors++; $display("FAIL midreset_abort: ldac=%0d aborted=%0d want 0 1", nldac[0] - lbase, nabort[0] - abase);
    end
    run_and_check("after_reset", 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_fast();
    for (int i = 0; i < 3; i++) begin
      run_and_check("fast", 1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      checks++; if (per_min[1] != 2 || per_max[1] != 2) begin
        errors++; $display("FAIL fast_sclk_period: got min %0d max %0d want 2 2", per_min[1], per_max[1]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; stb[k] = 1'b0; ina[k] = '0; inb[k] = '0; ena[k] = 1'b1; enb[k] = 1'b1;
    end
    test_reset();
    test_basic();
    test_disable();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
